// File: rtl/cpu_port_responder.sv
// cpu_port_responder: port-bus I/O responder with LED latch, synchronised
// switch input, interval timer and control/status register.
// Optional feature macro: PORT_TIMER_EN (timer, CTRL/STATUS, irq_o).
module cpu_port_responder #(
  parameter logic [7:0]  BASE_ADDR   = 8'h00,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       port_cyc_i,
  input  logic       port_stb_i,
  input  logic       port_we_i,
  input  logic [7:0] port_adr_i,
  input  logic [7:0] port_dat_i,
  output logic [7:0] port_dat_o,
  output logic       port_ack_o,
  input  logic [7:0] sw_i,
  output logic [7:0] led_o,
  output logic       irq_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_HOLD} state_t;

  localparam logic [2:0] WLOAD = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);

  state_t     state_q, state_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic       ack_q;
  logic [7:0] dat_q, dat_d;
  logic [7:0] led_q, led_d;
  logic [7:0] sw_meta_q, sw_sync_q;
  logic [7:0] rd_mux;
  logic       hit, commit, wr_c, rd_c;
  logic [1:0] sel;

  assign hit  = port_cyc_i & port_stb_i & (port_adr_i[7:2] == BASE_ADDR[7:2]);
  assign sel  = port_adr_i[1:0];
  // ACK is only entered from IDLE or WAIT, so state_d == ACK marks the commit edge.
  assign commit = (state_d == S_ACK);
  assign wr_c   = commit & port_we_i;
  assign rd_c   = commit & ~port_we_i;

  // Bus handshake: wait-state countdown, single-cycle ack, hold until strobe drops.
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          if (WAIT_STATES == 0) begin
            state_d = S_ACK;
          end else begin
            wcnt_d  = WLOAD;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!port_cyc_i || !port_stb_i) begin
          state_d = S_IDLE;
        end else if (wcnt_q == 3'd0) begin
          state_d = S_ACK;
        end else begin
          wcnt_d = wcnt_q - 3'd1;
        end
      end
      S_ACK:  state_d = S_HOLD;
      S_HOLD: if (!port_stb_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake state, ack and read-data registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      ack_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      ack_q   <= commit;
      dat_q   <= dat_d;
    end
  end

  assign port_ack_o = ack_q;
  assign port_dat_o = dat_q;
  assign dat_d      = rd_c ? rd_mux : '0;
  assign led_d      = (wr_c && sel == 2'd0) ? port_dat_i : led_q;
  assign led_o      = led_q;

  // LED latch and two-flop switch synchroniser.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_i;
      sw_sync_q <= sw_meta_q;
    end
  end

`ifdef PORT_TIMER_EN
  logic [7:0] reload_q, reload_d, count_q, count_d;
  logic       ten_q, ten_d, ien_q, ien_d, flag_q, flag_d;

  // Timer and CTRL update; the effective enable for this edge is the value
  // being written, so a disabling CTRL write freezes count immediately.
  always_comb begin
    reload_d = reload_q;
    count_d  = count_q;
    ten_d    = ten_q;
    ien_d    = ien_q;
    flag_d   = flag_q;
    if (wr_c && sel == 2'd3) begin
      ten_d = port_dat_i[0];
      ien_d = port_dat_i[1];
      if (port_dat_i[7]) flag_d = 1'b0;
    end
    if (wr_c && sel == 2'd2) begin
      reload_d = port_dat_i;
      count_d  = port_dat_i;
    end else if (ten_d) begin
      if (count_q == 8'd0) begin
        count_d = reload_q;
        flag_d  = 1'b1;
      end else begin
        count_d = count_q - 8'd1;
      end
    end
  end

  // Timer and control registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      reload_q <= '0;
      count_q  <= '0;
      ten_q    <= 1'b0;
      ien_q    <= 1'b0;
      flag_q   <= 1'b0;
    end else begin
      reload_q <= reload_d;
      count_q  <= count_d;
      ten_q    <= ten_d;
      ien_q    <= ien_d;
      flag_q   <= flag_d;
    end
  end

  assign irq_o = flag_q & ien_q;

  // Read data selection.
  always_comb begin
    rd_mux = '0;
    case (sel)
      2'd0: rd_mux = led_q;
      2'd1: rd_mux = sw_sync_q;
      2'd2: rd_mux = count_q;
      2'd3: rd_mux = {flag_q, 5'b0, ien_q, ten_q};
      default: rd_mux = '0;
    endcase
  end
`else
  assign irq_o = 1'b0;

  // Read data selection; timer addresses read as zero.
  always_comb begin
    rd_mux = '0;
    case (sel)
      2'd0: rd_mux = led_q;
      2'd1: rd_mux = sw_sync_q;
      default: rd_mux = '0;
    endcase
  end
`endif

endmodule

// File: tb/tb_cpu_port_responder.sv
// Directed + randomized bench for cpu_port_responder. Two instances share the
// bus: A at base 0x00 with one wait state, B at base 0x40 with three.
module tb_cpu_port_responder;
  logic       clk = 1'b0;
  logic       rst;
  logic       cyc, stb, we;
  logic [7:0] adr, dati, sw;
  logic [7:0] datA, datB, ledA, ledB;
  logic       ackA, ackB, irqA, irqB;

  int total = 0;
  int bad   = 0;
  int ecount = 0;

  cpu_port_responder #(.BASE_ADDR(8'h00), .WAIT_STATES(1)) u_a (
    .clk_i(clk), .rst_i(rst), .port_cyc_i(cyc), .port_stb_i(stb), .port_we_i(we),
    .port_adr_i(adr), .port_dat_i(dati), .port_dat_o(datA), .port_ack_o(ackA),
    .sw_i(sw), .led_o(ledA), .irq_o(irqA));

  cpu_port_responder #(.BASE_ADDR(8'h40), .WAIT_STATES(3)) u_b (
    .clk_i(clk), .rst_i(rst), .port_cyc_i(cyc), .port_stb_i(stb), .port_we_i(we),
    .port_adr_i(adr), .port_dat_i(dati), .port_dat_o(datB), .port_ack_o(ackB),
    .sw_i(sw), .led_o(ledB), .irq_o(irqB));

  always #5 clk = ~clk;
  always @(posedge clk) ecount <= ecount + 1;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One bus transfer; checks ack timing against the instance's wait states.
  task automatic xfer(input bit b, input logic w, input logic [1:0] r, input logic [7:0] d,
                      input int hold, output logic [7:0] rd, output int cedge);
    int ws;
    ws = b ? 3 : 1;
    rd = '0;
    cedge = 0;
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; dati = d;
    adr = (b ? 8'h40 : 8'h00) | {6'b0, r};
    for (int j = 0; j <= ws; j++) begin
      @(negedge clk);
      chk("ack_timing", 8'(b ? ackB : ackA), 8'(j == ws));
      chk("ack_other", 8'(b ? ackA : ackB), 8'h00);
      if (j == ws) begin
        rd = b ? datB : datA;
        cedge = ecount;
      end else begin
        chk("dat_idle", b ? datB : datA, 8'h00);
      end
    end
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      chk("ack_hold", 8'(b ? ackB : ackA), 8'h00);
      chk("dat_hold", b ? datB : datA, 8'h00);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("ack_after", 8'(b ? ackB : ackA), 8'h00);
  endtask

  // Wait so the next A transfer commits at an edge with (edges since enable) % 5 == want.
  task automatic align(input int e, input int want);
    for (int g = 0; g < 5; g++)
      if (((ecount + 4 - e) % 5) != want) @(negedge clk);
  endtask

  initial begin
    logic [7:0] rd, ledA_m, ledB_m, sw_m, d;
    int ce;
    bit b;
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; adr = '0; dati = '0; sw = '0;
    ledA_m = '0; ledB_m = '0; sw_m = '0;
    repeat (2) @(negedge clk);
    chk("rst_ackA", 8'(ackA), 8'h00);
    chk("rst_datA", datA, 8'h00);
    chk("rst_ledA", ledA, 8'h00);
    chk("rst_irqA", 8'(irqA), 8'h00);
    chk("rst_ackB", 8'(ackB), 8'h00);
    chk("rst_ledB", ledB, 8'h00);
    rst = 1'b0;

    // LED write/read on A
    xfer(0, 1, 2'd0, 8'hA5, 0, rd, ce);
    chk("led_wr", ledA, 8'hA5);
    chk("led_other", ledB, 8'h00);
    xfer(0, 0, 2'd0, 8'h00, 0, rd, ce);
    chk("led_rd", rd, 8'hA5);

    // Switch synchroniser and read-only SW register
    sw = 8'h3C; sw_m = 8'h3C;
    repeat (2) @(negedge clk);
    xfer(0, 0, 2'd1, 8'h00, 0, rd, ce);
    chk("sw_rd", rd, 8'h3C);
    xfer(0, 1, 2'd1, 8'hFF, 0, rd, ce);
    xfer(0, 0, 2'd1, 8'h00, 0, rd, ce);
    chk("sw_ro", rd, 8'h3C);

    // Strobe held after ack: single ack only
    xfer(0, 1, 2'd0, 8'h5A, 3, rd, ce);
    chk("led_hold", ledA, 8'h5A);
    ledA_m = 8'h5A;

    // Address miss: never acked
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h04; dati = 8'h77;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("miss_ackA", 8'(ackA), 8'h00);
      chk("miss_ackB", 8'(ackB), 8'h00);
    end
    cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("miss_led", ledA, 8'h5A);

    // Strobe dropped during WAIT on B: aborted
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h40; dati = 8'h11;
    repeat (2) @(negedge clk);
    stb = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_ack", 8'(ackB), 8'h00);
    end
    cyc = 1'b0;
    chk("abort_led", ledB, 8'h00);
    xfer(1, 1, 2'd0, 8'hC3, 1, rd, ce);
    chk("ledB_wr", ledB, 8'hC3);
    ledB_m = 8'hC3;
    xfer(1, 0, 2'd0, 8'h00, 0, rd, ce);
    chk("ledB_rd", rd, 8'hC3);

    // Randomized LED/SW traffic against simple register model
    for (int n = 0; n < 24; n++) begin
      b = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      case ($urandom_range(0, 3))
        0: begin
          xfer(b, 1, 2'd0, d, int'($urandom_range(0, 2)), rd, ce);
          if (b) ledB_m = d; else ledA_m = d;
          chk("rnd_ledA", ledA, ledA_m);
          chk("rnd_ledB", ledB, ledB_m);
        end
        1: begin
          xfer(b, 0, 2'd0, 8'h00, 0, rd, ce);
          chk("rnd_ledrd", rd, b ? ledB_m : ledA_m);
        end
        2: begin
          sw = d; sw_m = d;
          repeat (2) @(negedge clk);
          xfer(b, 0, 2'd1, 8'h00, 0, rd, ce);
          chk("rnd_swrd", rd, sw_m);
        end
        default: begin
          xfer(b, 1, 2'd1, d, 0, rd, ce);
          xfer(b, 0, 2'd1, 8'h00, 0, rd, ce);
          chk("rnd_swro", rd, sw_m);
        end
      endcase
    end

`ifdef PORT_TIMER_EN
    begin
      int e;
      xfer(0, 1, 2'd2, 8'd4, 0, rd, ce);
      xfer(0, 1, 2'd3, 8'h03, 0, rd, e);
      // Expiry every 5 edges from the enabling edge
      for (int i = 0; i < 10; i++) begin
        @(negedge clk);
        chk("irq_period", 8'(irqA), 8'((ecount - e + 1) >= 5));
      end
      xfer(0, 0, 2'd3, 8'h00, 0, rd, ce);
      chk("ctrl_rd", rd, 8'h83);
      xfer(0, 0, 2'd2, 8'h00, 0, rd, ce);
      chk("timer_rd", rd, 8'(4 - ((ce - e) % 5)));
      // W1C on an expiry edge: set wins
      align(e, 0);
      xfer(0, 1, 2'd3, 8'h83, 0, rd, ce);
      chk("w1c_expiry", 8'(irqA), 8'h01);
      // W1C on a non-expiry edge clears, next expiry sets again
      align(e, 2);
      xfer(0, 1, 2'd3, 8'h83, 0, rd, ce);
      chk("w1c_clear", 8'(irqA), 8'h00);
      repeat (3) @(negedge clk);
      chk("reexpire", 8'(irqA), 8'h01);
      // Disable freezes count at the disabling edge
      align(e, 2);
      xfer(0, 1, 2'd3, 8'h00, 0, rd, ce);
      repeat (4) @(negedge clk);
      xfer(0, 0, 2'd2, 8'h00, 0, rd, ce);
      chk("freeze", rd, 8'd3);
      xfer(0, 0, 2'd3, 8'h00, 0, rd, ce);
      chk("ctrl_dis", rd, 8'h80);
      chk("irq_dis", 8'(irqA), 8'h00);
    end
`else
    xfer(0, 1, 2'd2, 8'd4, 0, rd, ce);
    xfer(0, 1, 2'd3, 8'h03, 0, rd, ce);
    xfer(0, 0, 2'd2, 8'h00, 0, rd, ce);
    chk("notmr_rd2", rd, 8'h00);
    xfer(0, 0, 2'd3, 8'h00, 0, rd, ce);
    chk("notmr_rd3", rd, 8'h00);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("notmr_irq", 8'(irqA), 8'h00);
    end
`endif

    // Reset during WAIT on B: no ack afterwards
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 8'h40; dati = 8'h66;
    repeat (2) @(negedge clk);
    rst = 1'b1; cyc = 1'b0; stb = 1'b0;
    @(negedge clk);
    chk("rst_mid_ledA", ledA, 8'h00);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rst_mid_ack", 8'(ackB), 8'h00);
    end
    chk("rst_mid_ledB", ledB, 8'h00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
